// File: rtl/risc16_multicycle_core.sv
// Multicycle RISC16 core: FETCH/EXEC/MEM/HALT sequencer sharing one
// unified instruction/data memory port, with an 8x16 register file and a
// retired-instruction counter.
module risc16_multicycle_core #(
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  instret
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [15:0]       regs_q [8];
    logic [15:0]       regs_d [8];

    logic [2:0]        op, ra, rb, rc;
    logic [15:0]       simm7, imm10_ext;
    logic [15:0]       ra_val, rb_val, rc_val;
    logic [15:0]       eff_addr;
    logic [ADDR_W-1:0] pc_plus1;
    logic [15:0]       pc_plus1_ext;
    logic [15:0]       br_target;
    logic              wb_en;
    logic [15:0]       wb_data;

    assign op           = ir_q[15:13];
    assign ra           = ir_q[12:10];
    assign rb           = ir_q[9:7];
    assign rc           = ir_q[2:0];
    assign simm7        = {{9{ir_q[6]}}, ir_q[6:0]};
    assign imm10_ext    = {ir_q[9:0], 6'b0};
    assign ra_val       = regs_q[ra];
    assign rb_val       = regs_q[rb];
    assign rc_val       = regs_q[rc];
    assign eff_addr     = rb_val + simm7;
    assign pc_plus1     = pc_q + ADDR_W'(1);
    assign pc_plus1_ext = 16'(pc_plus1);
    assign br_target    = pc_plus1_ext + simm7;

    assign halted  = (state_q == S_HALT);
    assign pc      = pc_q;
    assign instret = instret_q;

    // Memory port: request only in FETCH/MEM and never while reset is sampled,
    // so an in-flight access is dropped the moment reset arrives.
    always_comb begin
        mem_req   = !rst && ((state_q == S_FETCH) || (state_q == S_MEM));
        mem_we    = (state_q == S_MEM) && (op == OP_SW);
        mem_addr  = (state_q == S_MEM) ? eff_addr[ADDR_W-1:0] : pc_q;
        mem_wdata = ra_val;
    end

    // Next-state, PC, counter and register-file update for each FSM phase.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        regs_d    = regs_q;
        wb_en     = 1'b0;
        wb_data   = 16'h0000;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d   = S_FETCH;
                pc_d      = pc_plus1;
                instret_d = instret_q + CNT_W'(1);
                case (op)
                    OP_ADD:  begin wb_en = 1'b1; wb_data = rb_val + rc_val; end
                    OP_ADDI: begin wb_en = 1'b1; wb_data = rb_val + simm7; end
                    OP_NAND: begin wb_en = 1'b1; wb_data = ~(rb_val & rc_val); end
                    OP_LUI:  begin wb_en = 1'b1; wb_data = imm10_ext; end
                    OP_SW, OP_LW: begin
                        state_d   = S_MEM;
                        pc_d      = pc_q;
                        instret_d = instret_q;
                    end
                    OP_BEQ: begin
                        if (ra_val == rb_val) begin
                            pc_d = br_target[ADDR_W-1:0];
                        end
                    end
                    default: begin
                        if (ir_q[6:0] != 7'd0) begin
                            state_d   = S_HALT;
                            pc_d      = pc_q;
                            instret_d = instret_q;
                        end else begin
                            wb_en   = 1'b1;
                            wb_data = pc_plus1_ext;
                            pc_d    = rb_val[ADDR_W-1:0];
                        end
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op == OP_LW) begin
                        wb_en   = 1'b1;
                        wb_data = mem_rdata;
                    end
                    pc_d      = pc_plus1;
                    instret_d = instret_q + CNT_W'(1);
                    state_d   = S_FETCH;
                end
            end
            default: begin
            end
        endcase
        if (wb_en && (ra != 3'd0)) begin
            regs_d[ra] = wb_data;
        end
    end

    // Architectural state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= ADDR_W'(RESET_PC);
            ir_q      <= 16'h0000;
            instret_q <= '0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_risc16_multicycle_core.sv
// Directed testbench for risc16_multicycle_core (8-bit address build) with a
// 256-word behavioural memory and a programmable wait-state count.
module tb_risc16_multicycle_core;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;
    localparam logic [15:0] HALT_I = 16'hE001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_wdata, mem_rdata;
    logic [31:0] instret;

    logic [15:0] mem [0:255];
    int          stall_n = 0;
    int          wait_cnt = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    risc16_multicycle_core #(.ADDR_W(8), .RESET_PC(0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .halted(halted), .pc(pc), .instret(instret)
    );

    always #5 clk = ~clk;

    // Wait-state generator: ready rises after stall_n waiting cycles.
    always @(posedge clk) begin
        if (!mem_req || mem_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    assign mem_ready = (wait_cnt >= stall_n);
    assign mem_rdata = mem[mem_addr];

    // Commit stores on the falling edge ahead of the completing rising edge.
    always @(negedge clk) begin
        if (mem_req && mem_ready && mem_we) mem[mem_addr] = mem_wdata;
    end

    function automatic logic [15:0] enc_rrr(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        return {op, a, b, 4'b0000, c};
    endfunction

    function automatic logic [15:0] enc_ri(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b, input int imm);
        return {op, a, b, 7'(imm)};
    endfunction

    function automatic logic [15:0] enc_lui(input logic [2:0] a, input int imm);
        return {OP_LUI, a, 10'(imm)};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_until_halt(input int max_cycles, output int cycles);
        cycles = 0;
        while (!halted && cycles < max_cycles) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!halted) cycles = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
        tests_run++; if (pc !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_pc: got %h expected 00", pc); end
        tests_run++; if (instret !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_instret: got %0d expected 0", instret); end
        tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
        rst = 1'b0;
        #1;
        tests_run++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_first_fetch: got req=%b we=%b expected req=1 we=0", mem_req, mem_we); end
        tests_run++; if (mem_addr !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_fetch_addr: got %h expected 00", mem_addr); end
    endtask

    task automatic test_alu();
        int cycles;
        clear_mem(); stall_n = 0;
        mem[0] = enc_ri(OP_ADDI, 1, 0, 5);
        mem[1] = enc_ri(OP_ADDI, 2, 0, -3);
        mem[2] = enc_rrr(OP_ADD, 3, 1, 2);
        mem[3] = HALT_I;
        do_reset();
        run_until_halt(100, cycles);
        tests_run++; if (cycles != 8) begin tests_failed++; $display("[TB] FAIL alu_cycles: got %0d expected 8", cycles); end
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("[TB] FAIL alu_halted: got %b expected 1", halted); end
        tests_run++; if (instret !== 32'd3) begin tests_failed++; $display("[TB] FAIL alu_instret: got %0d expected 3", instret); end
        tests_run++; if (pc !== 8'h03) begin tests_failed++; $display("[TB] FAIL alu_pc: got %h expected 03", pc); end
        repeat (5) @(posedge clk);
        #1;
        tests_run++; if (pc !== 8'h03 || instret !== 32'd3 || halted !== 1'b1 || mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL halt_absorbing: got pc=%h instret=%0d halted=%b req=%b expected pc=03 instret=3 halted=1 req=0", pc, instret, halted, mem_req); end
        clear_mem();
        mem[0] = enc_ri(OP_ADDI, 1, 0, 5);
        mem[1] = enc_ri(OP_ADDI, 2, 0, -3);
        mem[2] = enc_rrr(OP_ADD, 3, 1, 2);
        mem[3] = enc_ri(OP_SW, 3, 0, 50);
        mem[4] = HALT_I;
        mem[50] = 16'hDEAD;
        do_reset();
        run_until_halt(100, cycles);
        tests_run++; if (cycles != 11) begin tests_failed++; $display("[TB] FAIL alu_sw_cycles: got %0d expected 11", cycles); end
        tests_run++; if (mem[50] !== 16'h0002) begin tests_failed++; $display("[TB] FAIL alu_r3: got %h expected 0002", mem[50]); end
        tests_run++; if (instret !== 32'd4) begin tests_failed++; $display("[TB] FAIL alu_sw_instret: got %0d expected 4", instret); end
    endtask

    task automatic test_lui_nand();
        int cycles;
        clear_mem(); stall_n = 0;
        mem[0] = enc_lui(1, 10'h3FF);
        mem[1] = enc_ri(OP_ADDI, 1, 1, 63);
        mem[2] = enc_rrr(OP_NAND, 2, 1, 1);
        mem[3] = enc_ri(OP_SW, 1, 0, 51);
        mem[4] = enc_ri(OP_SW, 2, 0, 52);
        mem[5] = HALT_I;
        mem[52] = 16'hAAAA;
        do_reset();
        run_until_halt(100, cycles);
        tests_run++; if (cycles < 0) begin tests_failed++; $display("[TB] FAIL lui_timeout: got no halt expected halt"); end
        tests_run++; if (mem[51] !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL lui_r1: got %h expected ffff", mem[51]); end
        tests_run++; if (mem[52] !== 16'h0000) begin tests_failed++; $display("[TB] FAIL nand_r2: got %h expected 0000", mem[52]); end
        tests_run++; if (instret !== 32'd5) begin tests_failed++; $display("[TB] FAIL lui_instret: got %0d expected 5", instret); end
    endtask

    task automatic test_mem_stall();
        int cycles = 0;
        int stab_err = 0;
        logic pending = 1'b0;
        logic p_we = 1'b0;
        logic [7:0] p_addr = 8'h00;
        logic [15:0] p_wdata = 16'h0000;
        clear_mem();
        mem[0] = enc_lui(1, 10'h048);
        mem[1] = enc_ri(OP_ADDI, 1, 1, 52);
        mem[2] = enc_ri(OP_SW, 1, 0, 20);
        mem[3] = enc_ri(OP_LW, 4, 0, 20);
        mem[4] = enc_ri(OP_SW, 4, 0, 21);
        mem[5] = HALT_I;
        stall_n = 3;
        do_reset();
        while (!halted && cycles < 200) begin
            @(negedge clk);
            if (pending && (mem_req !== 1'b1 || mem_addr !== p_addr || mem_we !== p_we || (p_we && mem_wdata !== p_wdata))) stab_err++;
            pending = mem_req && !mem_ready;
            p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
            @(posedge clk); #1;
            cycles++;
        end
        stall_n = 0;
        tests_run++; if (cycles != 42 || !halted) begin tests_failed++; $display("[TB] FAIL stall_cycles: got %0d halted=%b expected 42 halted=1", cycles, halted); end
        tests_run++; if (stab_err != 0) begin tests_failed++; $display("[TB] FAIL stall_stability: got %0d unstable cycles expected 0", stab_err); end
        tests_run++; if (mem[20] !== 16'h1234) begin tests_failed++; $display("[TB] FAIL stall_sw: got %h expected 1234", mem[20]); end
        tests_run++; if (mem[21] !== 16'h1234) begin tests_failed++; $display("[TB] FAIL stall_lw_r4: got %h expected 1234", mem[21]); end
        tests_run++; if (pc !== 8'h05 || instret !== 32'd5) begin tests_failed++; $display("[TB] FAIL stall_pc_instret: got pc=%h instret=%0d expected pc=05 instret=5", pc, instret); end
    endtask

    task automatic test_branch_jalr();
        int cycles;
        clear_mem(); stall_n = 0;
        mem[0] = enc_ri(OP_ADDI, 1, 0, 1);
        mem[1] = enc_ri(OP_ADDI, 2, 0, 2);
        mem[2] = enc_ri(OP_BEQ, 1, 2, 5);
        mem[3] = enc_ri(OP_ADDI, 3, 0, 0);
        mem[4] = enc_ri(OP_BEQ, 0, 0, -1);
        mem[8] = HALT_I;
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        tests_run++; if (pc !== 8'h04 || halted !== 1'b0) begin tests_failed++; $display("[TB] FAIL beq_loop_pc: got pc=%h halted=%b expected pc=04 halted=0", pc, halted); end
        tests_run++; if (instret !== 32'd10) begin tests_failed++; $display("[TB] FAIL beq_loop_instret: got %0d expected 10", instret); end
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 8'h04) begin tests_failed++; $display("[TB] FAIL beq_loop_fetch: got req=%b addr=%h expected req=1 addr=04", mem_req, mem_addr); end
        clear_mem();
        mem[0]  = enc_ri(OP_ADDI, 5, 0, 10);
        for (int i = 1; i < 6; i++) mem[i] = enc_ri(OP_ADDI, 0, 0, 0);
        mem[6]  = enc_ri(OP_JALR, 7, 5, 0);
        mem[7]  = HALT_I;
        mem[10] = enc_ri(OP_SW, 7, 0, 60);
        mem[11] = enc_ri(OP_ADDI, 6, 0, 20);
        mem[12] = enc_ri(OP_JALR, 6, 6, 0);
        mem[13] = HALT_I;
        mem[20] = enc_ri(OP_SW, 6, 0, 61);
        mem[21] = HALT_I;
        do_reset();
        run_until_halt(200, cycles);
        tests_run++; if (mem[60] !== 16'h0007) begin tests_failed++; $display("[TB] FAIL jalr_link: got %h expected 0007", mem[60]); end
        tests_run++; if (mem[61] !== 16'h000D) begin tests_failed++; $display("[TB] FAIL jalr_same_reg: got %h expected 000d", mem[61]); end
        tests_run++; if (pc !== 8'd21 || instret !== 32'd11) begin tests_failed++; $display("[TB] FAIL jalr_pc_instret: got pc=%0d instret=%0d expected pc=21 instret=11", pc, instret); end
    endtask

    task automatic test_wrap_r0();
        int cycles;
        clear_mem(); stall_n = 0;
        mem[0]   = enc_ri(OP_BEQ, 3, 0, 2);
        mem[1]   = enc_ri(OP_SW, 0, 0, 62);
        mem[2]   = HALT_I;
        mem[3]   = enc_ri(OP_ADDI, 3, 0, 1);
        mem[4]   = enc_lui(1, 3);
        mem[5]   = enc_ri(OP_ADDI, 1, 1, 63);
        mem[6]   = enc_ri(OP_JALR, 0, 1, 0);
        mem[255] = enc_ri(OP_ADDI, 0, 0, 9);
        mem[62]  = 16'h5555;
        do_reset();
        repeat (12) @(posedge clk);
        #1;
        tests_run++; if (pc !== 8'h00 || mem_req !== 1'b1 || mem_addr !== 8'h00) begin tests_failed++; $display("[TB] FAIL wrap_fetch: got pc=%h req=%b addr=%h expected pc=00 req=1 addr=00", pc, mem_req, mem_addr); end
        run_until_halt(100, cycles);
        tests_run++; if (mem[62] !== 16'h0000) begin tests_failed++; $display("[TB] FAIL r0_zero: got %h expected 0000", mem[62]); end
        tests_run++; if (pc !== 8'h02 || instret !== 32'd8) begin tests_failed++; $display("[TB] FAIL wrap_pc_instret: got pc=%h instret=%0d expected pc=02 instret=8", pc, instret); end
    endtask

    task automatic test_reset_mid_mem();
        int cycles;
        logic found = 1'b0;
        clear_mem(); stall_n = 0;
        mem[0]  = enc_ri(OP_ADDI, 1, 0, 7);
        mem[1]  = enc_ri(OP_SW, 1, 0, 30);
        mem[2]  = HALT_I;
        mem[30] = 16'h0BAD;
        do_reset();
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin stall_n = 1000; found = 1'b1; end
        end
        tests_run++; if (!found) begin tests_failed++; $display("[TB] FAIL abort_reach_mem: got no store request expected one"); end
        repeat (3) @(negedge clk);
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 8'd30) begin tests_failed++; $display("[TB] FAIL abort_stalled: got req=%b addr=%h expected req=1 addr=1e", mem_req, mem_addr); end
        rst = 1'b1;
        #1;
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_req_drop: got %b expected 0", mem_req); end
        @(posedge clk); #1;
        tests_run++; if (pc !== 8'h00 || instret !== 32'd0) begin tests_failed++; $display("[TB] FAIL abort_reset_state: got pc=%h instret=%0d expected pc=00 instret=0", pc, instret); end
        tests_run++; if (mem[30] !== 16'h0BAD) begin tests_failed++; $display("[TB] FAIL abort_no_write: got %h expected 0bad", mem[30]); end
        rst = 1'b0; stall_n = 0;
        #1;
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin tests_failed++; $display("[TB] FAIL abort_refetch: got req=%b addr=%h expected req=1 addr=00", mem_req, mem_addr); end
        run_until_halt(100, cycles);
        tests_run++; if (mem[30] !== 16'h0007 || instret !== 32'd2 || pc !== 8'h02) begin tests_failed++; $display("[TB] FAIL abort_rerun: got mem=%h instret=%0d pc=%h expected mem=0007 instret=2 pc=02", mem[30], instret, pc); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_alu();
        test_lui_nand();
        test_mem_stall();
        test_branch_jalr();
        test_wrap_r0();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/risc16_multicycle_core.md
RISC16_MULTICYCLE_CORE -- requirements
Module: risc16_multicycle_core

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory/PC address width (8..16); addresses are word addresses.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mem_req  output  1  memory transaction request.
REQ-007 SHALL have port mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-008 SHALL have port mem_addr  output  ADDR_W  word address; valid while mem_req=1.
REQ-009 SHALL have port mem_wdata  output  16  store data; valid while mem_req=1 and mem_we=1.
REQ-010 SHALL have port mem_rdata  input  16  read data; sampled on the completing cycle.
REQ-011 SHALL have port mem_ready  input  1  transaction completes on a cycle where mem_req=1 and mem_ready=1.
REQ-012 SHALL have port halted  output  1  core stopped on HALT.
REQ-013 SHALL have port pc  output  ADDR_W  current architectural PC.
REQ-014 SHALL have port instret  output  CNT_W  count of retired instructions.

Function
REQ-015 SHALL use a unified instruction/data memory through the single mem_* port.
REQ-016 SHALL decode op=ir[15:13], rA=ir[12:10], rB=ir[9:7], rC=ir[2:0], simm7=sign-extended ir[6:0], imm10=ir[9:0].
REQ-017 SHALL implement ADD(000) rA=rB+rC; ADDI(001) rA=rB+simm7; NAND(010) rA=~(rB&rC); LUI(011) rA={imm10,6'b0}; SW(100) mem[rB+simm7]=rA; LW(101) rA=mem[rB+simm7]; BEQ(110) if rA==rB then PC=PC+1+simm7; JALR(111) rA=PC+1, PC=rB.
REQ-018 SHALL treat JALR with ir[6:0]!=0 as HALT: no register write, PC unchanged, enter HALT.
REQ-019 SHALL hold 8 registers x 16 bits internally; r0 reads 0 and writes to r0 are discarded.
REQ-020 SHALL truncate all 16-bit arithmetic modulo 2^16; PC and effective addresses SHALL use the low ADDR_W bits, wrapping modulo 2^ADDR_W.
REQ-021 SHALL implement FSM states FETCH, EXEC, MEM, HALT.
REQ-022 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on completion latch ir<=mem_rdata, go EXEC; otherwise stay.
REQ-023 EXEC (1 cycle, mem_req=0): LW/SW go MEM; HALT goes HALT; all others write back, update PC, increment instret, go FETCH.
REQ-024 MEM: mem_req=1, mem_addr=rB+simm7, mem_we=1 for SW (mem_wdata=rA) else 0; on completion LW writes rA<=mem_rdata, PC<=PC+1, instret+1, go FETCH.
REQ-025 mem_req, mem_we, mem_addr, mem_wdata SHALL stay stable from assertion until completion; mem_ready SHALL be ignored while mem_req=0.
REQ-026 Latency with mem_ready tied 1: ALU/branch/JALR = 2 cycles, LW/SW = 3 cycles; each stall cycle adds 1.
REQ-027 HALT SHALL be absorbing: mem_req=0, halted=1, no state changes until rst.
REQ-028 instret SHALL wrap modulo 2^CNT_W; HALT SHALL not be counted.
REQ-029 JALR with rA==rB SHALL use the old rB as target and write PC+1 to rA.

Reset
REQ-030 While rst=1 at a rising edge: state<=FETCH, pc<=RESET_PC, all registers<=0, ir<=0, instret<=0, halted<=0.
REQ-031 mem_req SHALL be 0 during the cycle rst is asserted-sampled and SHALL assert in FETCH on the first cycle after rst deasserts; an outstanding transaction SHALL be abandoned without side effects.

Verification
REQ-032 Program ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; HALT, mem_ready=1 -> r3=2, halted=1, instret=3, pc=3.
REQ-033 LUI r1,0x3FF; ADDI r1,r1,63 -> r1=0xFFFF; NAND r2,r1,r1 -> r2=0.
REQ-034 SW r1,r0,20 with r1=0x1234, then LW r4,r0,20, mem_ready low 3 cycles per access -> r4=0x1234; mem_addr/mem_wdata stable across stalls.
REQ-035 BEQ r0,r0,-1 at pc=4 loops at 4; BEQ with r1!=r2 -> pc+1; JALR r7,r5 with r5=10 at pc=6 -> r7=7, pc=10.
REQ-036 ADDR_W=8, ADDI at pc=0xFF -> next fetch address 0x00; ADDI r0,r0,9 -> r0 reads 0.
REQ-037 rst asserted mid-MEM stall -> no register/memory side effect, next fetch at RESET_PC, instret=0.
